// File: rtl/bank_pkg.sv
// Shared definitions for the cache bank: offset status encoding used by the
// per-offset trackers and the eviction sequencer's state encoding.
package bank_pkg;

  // Per-offset status as produced by the offset trackers (2'b11 is illegal).
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] SYNC  = 2'b01;
  localparam logic [1:0] DIRTY = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } evict_state_e;

endpackage

// File: rtl/bank_htu_evict_pick.sv
// Lowest-set-bit picker: returns the index and one-hot of the lowest set bit
// of a mask. An all-zero mask yields index 0 and an all-zero one-hot.
module bank_htu_evict_pick #(
  parameter int OFFSET_NUM   = 4,
  parameter int OFFSET_IDX_W = $clog2(OFFSET_NUM)
) (
  input  logic [OFFSET_NUM-1:0]   mask_i,
  output logic [OFFSET_IDX_W-1:0] idx_o,
  output logic [OFFSET_NUM-1:0]   onehot_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = mask_i & (~mask_i + 1'b1);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this
    // block purely combinational; a path that leaves idx_o unassigned would
    // infer a latch.
    idx_o = '0;
    for (int k = OFFSET_NUM - 1; k >= 0; k--) begin
      if (mask_i[k]) idx_o = OFFSET_IDX_W'(k);
    end
  end

endmodule

// File: rtl/bank_htu_evict.sv
// Eviction writeback sequencer for one cache bank. Snapshots the victim
// line's offset statuses, issues one writeback per dirty offset (lowest index
// first) over valid/ready, pulses a clear to the matching tracker on each
// accepted writeback and signals completion once the line is clean.
module bank_htu_evict
  import bank_pkg::*;
#(
  parameter int OFFSET_NUM   = 4,
  parameter int LINE_ADDR_W  = 26,
  parameter int OFFSET_IDX_W = $clog2(OFFSET_NUM)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    evict_valid_i,
  output logic                    evict_ready_o,
  input  logic [LINE_ADDR_W-1:0]  evict_line_addr_i,
  input  logic [2*OFFSET_NUM-1:0] offset_status_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [LINE_ADDR_W-1:0]  wb_line_addr_o,
  output logic [OFFSET_IDX_W-1:0] wb_offset_o,
  output logic [OFFSET_NUM-1:0]   offset_clear_o,
  output logic                    evict_done_o,
  output logic                    busy_o
);

  evict_state_e            state_q, state_d;
  logic [OFFSET_NUM-1:0]   dirty_mask_q, dirty_mask_d;
  logic [LINE_ADDR_W-1:0]  line_addr_q, line_addr_d;

  logic [OFFSET_NUM-1:0]   status_dirty;
  logic [OFFSET_IDX_W-1:0] pick_idx;
  logic [OFFSET_NUM-1:0]   pick_onehot;
  logic                    wb_fire;

  bank_htu_evict_pick #(
    .OFFSET_NUM   (OFFSET_NUM),
    .OFFSET_IDX_W (OFFSET_IDX_W)
  ) u_pick (
    .mask_i   (dirty_mask_q),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Flag which offsets of the incoming snapshot are DIRTY; SYNC, EMPTY and
  // the illegal 2'b11 encoding all count as clean.
  always_comb begin
    status_dirty = '0;
    for (int k = 0; k < OFFSET_NUM; k++) begin
      status_dirty[k] = (offset_status_i[2*k +: 2] == DIRTY);
    end
  end

  // Handshake outputs decode registered state only; the clear pulse is the
  // single combinational path, gated by the accepted writeback.
  assign evict_ready_o  = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign wb_valid_o     = (state_q == ISSUE);
  assign evict_done_o   = (state_q == DONE);
  assign wb_line_addr_o = line_addr_q;
  assign wb_offset_o    = pick_idx;
  assign wb_fire        = wb_valid_o & wb_ready_i;
  assign offset_clear_o = wb_fire ? pick_onehot : '0;

  // Next-state logic: accept and snapshot in IDLE, retire one dirty offset
  // per handshake in ISSUE, pulse completion for one cycle in DONE.
  always_comb begin
    state_d      = state_q;
    dirty_mask_d = dirty_mask_q;
    line_addr_d  = line_addr_q;
    unique case (state_q)
      IDLE: begin
        if (evict_valid_i) begin
          line_addr_d  = evict_line_addr_i;
          dirty_mask_d = status_dirty;
          state_d      = (|status_dirty) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (wb_ready_i) begin
          dirty_mask_d = dirty_mask_q & ~pick_onehot;
          if (dirty_mask_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, mask and address registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments make every flop update from the values
    // present before the edge, so register order inside the block is moot.
    if (rst_i) begin
      state_q      <= IDLE;
      dirty_mask_q <= '0;
      line_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      dirty_mask_q <= dirty_mask_d;
      line_addr_q  <= line_addr_d;
    end
  end

endmodule

// File: tb/tb_bank_htu_evict.sv
// Scoreboard bench for bank_htu_evict: directed evictions push the expected
// writeback/done events (with their cycle numbers) into a queue; a monitor
// on the falling edge pops and compares them as the DUT presents them.
module tb_bank_htu_evict;
  import bank_pkg::*;

  localparam int OFFSET_NUM   = 4;
  localparam int LINE_ADDR_W  = 26;
  localparam int OFFSET_IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic                    evict_valid_i;
  logic                    evict_ready_o;
  logic [LINE_ADDR_W-1:0]  evict_line_addr_i;
  logic [2*OFFSET_NUM-1:0] offset_status_i;
  logic                    wb_valid_o;
  logic                    wb_ready_i;
  logic [LINE_ADDR_W-1:0]  wb_line_addr_o;
  logic [OFFSET_IDX_W-1:0] wb_offset_o;
  logic [OFFSET_NUM-1:0]   offset_clear_o;
  logic                    evict_done_o;
  logic                    busy_o;

  bank_htu_evict #(
    .OFFSET_NUM   (OFFSET_NUM),
    .LINE_ADDR_W  (LINE_ADDR_W),
    .OFFSET_IDX_W (OFFSET_IDX_W)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .evict_valid_i     (evict_valid_i),
    .evict_ready_o     (evict_ready_o),
    .evict_line_addr_i (evict_line_addr_i),
    .offset_status_i   (offset_status_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_line_addr_o    (wb_line_addr_o),
    .wb_offset_o       (wb_offset_o),
    .offset_clear_o    (offset_clear_o),
    .evict_done_o      (evict_done_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                     is_done;
    int                     cyc;
    logic [LINE_ADDR_W-1:0] addr;
    logic [OFFSET_IDX_W-1:0] off;
    logic [OFFSET_NUM-1:0]  clr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Cycle counter: during the period after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pack4(input logic [1:0] s0, input logic [1:0] s1,
                                       input logic [1:0] s2, input logic [1:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push_wb(input int c, input logic [LINE_ADDR_W-1:0] a,
                         input logic [OFFSET_IDX_W-1:0] o, input logic [OFFSET_NUM-1:0] clr);
    exp_t e;
    e.is_done = 1'b0; e.cyc = c; e.addr = a; e.off = o; e.clr = clr;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.cyc = c; e.addr = '0; e.off = '0; e.clr = '0;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Present a request; returns the accept cycle T. Leaves the bench at T+1.
  task automatic start_evict(input logic [LINE_ADDR_W-1:0] a, input logic [7:0] st, output int t);
    int n;
    n = 0;
    evict_valid_i     = 1'b1;
    evict_line_addr_i = a;
    offset_status_i   = st;
    while (!evict_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!evict_ready_o) begin
      errors++;
      $display("FAIL accept timeout: got ready=0, expected ready=1 within 20 cycles");
    end
    t = cyc;
    @(posedge clk); #1;
    evict_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " evict_ready_o"},  {31'd0, evict_ready_o}, 32'd1);
    check({tag, " wb_valid_o"},     {31'd0, wb_valid_o}, 32'd0);
    check({tag, " busy_o"},         {31'd0, busy_o}, 32'd0);
    check({tag, " evict_done_o"},   {31'd0, evict_done_o}, 32'd0);
    check({tag, " offset_clear_o"}, {28'd0, offset_clear_o}, 32'd0);
    check({tag, " wb_offset_o"},    {30'd0, wb_offset_o}, 32'd0);
    check({tag, " wb_line_addr_o"}, {6'd0, wb_line_addr_o}, 32'd0);
  endtask

  // Monitor: compares every handshake and done pulse against the scoreboard
  // and enforces stability of a stalled writeback.
  logic                    stall_prev = 1'b0;
  logic                    rst_prev   = 1'b1;
  logic [OFFSET_IDX_W-1:0] off_prev;
  logic [LINE_ADDR_W-1:0]  addr_prev;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected writeback: got offset %0d at cycle %0d, expected none", wb_offset_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb kind",   {31'd0, mon_e.is_done}, 32'd0);
          check("wb cycle",  cyc, mon_e.cyc);
          check("wb offset", {30'd0, wb_offset_o}, {30'd0, mon_e.off});
          check("wb addr",   {6'd0, wb_line_addr_o}, {6'd0, mon_e.addr});
          check("wb clear",  {28'd0, offset_clear_o}, {28'd0, mon_e.clr});
        end
      end else begin
        check("clear without handshake", {28'd0, offset_clear_o}, 32'd0);
      end
      if (evict_done_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected done: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("done kind",  {31'd0, mon_e.is_done}, 32'd1);
          check("done cycle", cyc, mon_e.cyc);
        end
      end
      if (stall_prev && !rst_prev) begin
        check("stall wb_valid held", {31'd0, wb_valid_o}, 32'd1);
        check("stall offset stable", {30'd0, wb_offset_o}, {30'd0, off_prev});
        check("stall addr stable",   {6'd0, wb_line_addr_o}, {6'd0, addr_prev});
      end
    end
    stall_prev = wb_valid_o && !wb_ready_i;
    rst_prev   = rst_i;
    off_prev   = wb_offset_o;
    addr_prev  = wb_line_addr_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_i             = 1'b1;
    evict_valid_i     = 1'b0;
    evict_line_addr_i = '0;
    offset_status_i   = '0;
    wb_ready_i        = 1'b1;

    // Reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle_outputs("reset");
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Clean line: done at T+1, ready again at T+2, no writeback
    start_evict(26'h0123456, pack4(SYNC, EMPTY, SYNC, EMPTY), t);
    push_done(t + 1);
    check("clean wb_valid T+1", {31'd0, wb_valid_o}, 32'd0);
    check("clean ready T+1",    {31'd0, evict_ready_o}, 32'd0);
    check("clean busy T+1",     {31'd0, busy_o}, 32'd1);
    wait_until(t + 2);
    check("clean ready T+2",    {31'd0, evict_ready_o}, 32'd1);
    drain("clean");

    // All dirty, back-to-back
    start_evict(26'h155AAAA, pack4(DIRTY, DIRTY, DIRTY, DIRTY), t);
    push_wb(t + 1, 26'h155AAAA, 2'd0, 4'b0001);
    push_wb(t + 2, 26'h155AAAA, 2'd1, 4'b0010);
    push_wb(t + 3, 26'h155AAAA, 2'd2, 4'b0100);
    push_wb(t + 4, 26'h155AAAA, 2'd3, 4'b1000);
    push_done(t + 5);
    check("alldirty ready T+1", {31'd0, evict_ready_o}, 32'd0);
    wait_until(t + 6);
    check("alldirty ready T+6", {31'd0, evict_ready_o}, 32'd1);
    drain("alldirty");

    // Backpressure: offsets 1 and 3, ready low for three cycles
    wb_ready_i = 1'b0;
    start_evict(26'h0ABCDEF, pack4(SYNC, DIRTY, EMPTY, DIRTY), t);
    push_wb(t + 4, 26'h0ABCDEF, 2'd1, 4'b0010);
    push_wb(t + 5, 26'h0ABCDEF, 2'd3, 4'b1000);
    push_done(t + 6);
    check("bp wb_valid T+1", {31'd0, wb_valid_o}, 32'd1);
    check("bp offset T+1",   {30'd0, wb_offset_o}, 32'd1);
    wait_until(t + 4);
    wb_ready_i = 1'b1;
    wait_until(t + 7);
    drain("backpressure");

    // Illegal status 11 treated as clean: only offset 1 written back
    start_evict(26'h3000001, pack4(2'b11, DIRTY, 2'b11, EMPTY), t);
    push_wb(t + 1, 26'h3000001, 2'd1, 4'b0010);
    push_done(t + 2);
    wait_until(t + 3);
    drain("illegal");

    // Reset after the second handshake: no more clears, no done
    start_evict(26'h2AAAAAA, pack4(DIRTY, DIRTY, DIRTY, DIRTY), t);
    push_wb(t + 1, 26'h2AAAAAA, 2'd0, 4'b0001);
    push_wb(t + 2, 26'h2AAAAAA, 2'd1, 4'b0010);
    wait_until(t + 3);
    rst_i      = 1'b1;
    wb_ready_i = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst_i      = 1'b0;
    wb_ready_i = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    drain("midreset");

    // Busy rejection: request held with new data during ISSUE/DONE
    start_evict(26'h0000ABC, pack4(DIRTY, EMPTY, DIRTY, EMPTY), t);
    evict_valid_i     = 1'b1;
    evict_line_addr_i = 26'h2222222;
    offset_status_i   = pack4(DIRTY, DIRTY, DIRTY, DIRTY);
    push_wb(t + 1, 26'h0000ABC, 2'd0, 4'b0001);
    push_wb(t + 2, 26'h0000ABC, 2'd2, 4'b0100);
    push_done(t + 3);
    push_wb(t + 5, 26'h2222222, 2'd0, 4'b0001);
    push_wb(t + 6, 26'h2222222, 2'd1, 4'b0010);
    push_wb(t + 7, 26'h2222222, 2'd2, 4'b0100);
    push_wb(t + 8, 26'h2222222, 2'd3, 4'b1000);
    push_done(t + 9);
    wait_until(t + 3);
    check("busy ready in DONE", {31'd0, evict_ready_o}, 32'd0);
    wait_until(t + 4);
    check("busy ready after done", {31'd0, evict_ready_o}, 32'd1);
    @(posedge clk); #1;
    evict_valid_i = 1'b0;
    check("busy second accepted", {31'd0, busy_o}, 32'd1);
    wait_until(t + 10);
    drain("busy");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_htu_evict.md
# bank_htu_evict

Eviction writeback sequencer for one cache bank. It sits directly downstream of the per-offset status trackers in the hit-test unit. When a victim cacheline is chosen, it takes a snapshot of that line's offset statuses and issues one writeback request per DIRTY offset, lowest index first, over a valid/ready handshake. After each accepted writeback it pulses a clear back to the matching tracker, and it signals completion once the line is clean.

## Interface

Parameters:
- OFFSET_NUM, 4: offsets per cacheline; power of two, at least 2.
- LINE_ADDR_W, 26: width of the cacheline address.
- OFFSET_IDX_W, $clog2(OFFSET_NUM): width of an offset index.

Ports:
- clk_i  in  1  bank clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- evict_valid_i  in  1  eviction request.
- evict_ready_o  out  1  block is idle and can accept a request.
- evict_line_addr_i  in  LINE_ADDR_W  victim line address.
- offset_status_i  in  2*OFFSET_NUM  packed per-offset status; offset k occupies bits [2k+1:2k]; EMPTY=00, SYNC=01, DIRTY=10.
- wb_valid_o  out  1  writeback request valid.
- wb_ready_i  in  1  downstream accepts the writeback.
- wb_line_addr_o  out  LINE_ADDR_W  latched victim address.
- wb_offset_o  out  OFFSET_IDX_W  index of the offset being written back.
- offset_clear_o  out  OFFSET_NUM  one-hot, single-cycle clear pulse to the matching offset tracker.
- evict_done_o  out  1  single-cycle completion pulse.
- busy_o  out  1  high in any state other than IDLE.

## Operation

- State machine has three states: IDLE, ISSUE, DONE.
- IDLE:
  - evict_ready_o=1.
  - On evict_valid_i, latch evict_line_addr_i and dirty_mask[k] = (status_k == DIRTY).
  - Next state is ISSUE if the mask is nonzero, otherwise DONE.
- ISSUE:
  - wb_valid_o=1; wb_offset_o = index of the lowest set bit of dirty_mask.
  - On wb_ready_i:
    - clear that mask bit;
    - drive offset_clear_o = one-hot of that index in the same cycle;
    - if the mask becomes zero, next state is DONE; otherwise stay in ISSUE and present the next offset in the following cycle.
- DONE: evict_done_o=1 for exactly one cycle, then return to IDLE.
- Status 11 (illegal) and SYNC are both treated as not dirty; neither produces a writeback.
- wb_line_addr_o, wb_offset_o and wb_valid_o must stay stable while wb_valid_o=1 and wb_ready_i=0. wb_valid_o never drops before the handshake completes.
- Requests in ISSUE or DONE are not accepted (evict_ready_o=0). The requester must hold evict_valid_i.
- offset_status_i is sampled only in the accept cycle. Later changes have no effect on an eviction in progress.

## Timing

- Reset values:
  - state IDLE;
  - dirty_mask, latched address and wb_offset_o all 0;
  - wb_valid_o=0, offset_clear_o=0, evict_done_o=0, busy_o=0;
  - evict_ready_o=1.
- Accept in cycle T:
  - first wb_valid_o in T+1;
  - with wb_ready_i held high, offsets issue back-to-back, one per cycle;
  - D dirty offsets give evict_done_o in T+D+1;
  - a clean line gives evict_done_o in T+1.
- Earliest next accept is the cycle after evict_done_o.
- Each cycle wb_ready_i is low while wb_valid_o is high adds one cycle of latency.
- evict_ready_o, wb_valid_o, evict_done_o and busy_o are decoded from registered state only. There is no combinational path from any input to any output.
- offset_clear_o is the one exception: it is combinational as wb_valid_o & wb_ready_i, decoded by wb_offset_o.
- rst_i asserted mid-eviction:
  - next cycle is IDLE with all outputs at reset values;
  - no evict_done_o and no further offset_clear_o;
  - writebacks not yet issued are dropped.

## Structure

- Shared package bank_pkg holds:
  - the offset status constants EMPTY, SYNC and DIRTY, shared with the offset trackers;
  - the state encoding IDLE=2'b00, ISSUE=2'b01, DONE=2'b10.
- One sub-module, bank_htu_evict_pick, finds the lowest set bit of dirty_mask. It is parameterised by OFFSET_NUM and outputs an index plus a one-hot vector.
- The top level holds the FSM, the mask and address registers, and the handshake logic.

## Test plan

- Clean line: statuses {SYNC,EMPTY,SYNC,EMPTY}, accept at T → no wb_valid_o; evict_done_o in T+1; evict_ready_o returns in T+2.
- All dirty: 4×DIRTY, address 0x155AAAA, wb_ready_i=1 → wb_offset_o 0,1,2,3 in T+1..T+4; offset_clear_o 0001,0010,0100,1000 in the same cycles; done in T+5.
- Backpressure: dirty offsets 1 and 3, wb_ready_i low for 3 cycles → offset 1 held stable for 3 cycles; then offset 1, then 3; done in T+6.
- Illegal status: statuses {11,DIRTY,11,EMPTY}, with offset 0's field = 11 → only offset 1 is written back.
- Reset mid-eviction: 4×DIRTY, rst_i asserted after the second handshake → next cycle is IDLE with all outputs 0, evict_ready_o=1, and no done pulse.
- Busy rejection: evict_valid_i held during ISSUE with a changed offset_status_i → no effect; the new request is accepted in the cycle after the done pulse.
